dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the RISC-V core: it is the slave end of the load/store path. It accepts one load or store request at a time over a valid/ready handshake, spends a programmable number of wait states, then returns read data or completion on a second valid/ready channel. It performs RISC-V funct3 byte/half/word lane handling, sign/zero extension and access checking. It replaces the zero-latency data memory when the core moves to a stalling, handshaked memory interface.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit storage words. Valid byte addresses are 0 to 4*DEPTH_WORDS-1.
- WAIT_STATES, 1: extra cycles between request accept and response, range 0–15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_write  in  1  1 = store, 0 = load.
- req_fn3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors.
- rsp_err  out  1  access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid&&req_ready, latch write, fn3, addr and wdata.
  - Go to WAIT with the counter loaded to WAIT_STATES-1, or directly to RESP if WAIT_STATES=0.
- **WAIT**
  - Counter decrements each cycle.
  - At 0, go to RESP. The store commit and load capture happen on this same transition edge.
- **RESP**
  - rsp_valid=1; rsp_rdata and rsp_err stay stable.
  - Return to IDLE on rsp_valid&&rsp_ready.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other fn3 sets err.
- Alignment errors:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- Range error: addr[31:2] ≥ DEPTH_WORDS.
- On error, no write occurs, rsp_rdata=0 and rsp_err=1.
- Stores write only the addressed lanes:
  - SB: byte lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - SW: all four lanes.
- Loads extract the addressed byte or half, then extend:
  - LB, LH: sign-extend to 32 bits.
  - LBU, LHU: zero-extend to 32 bits.
- Stores respond with rsp_rdata=0 and rsp_err=0.
- Storage is not reset; contents survive reset.

## Timing
- Reset values:
  - State is IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 while reset is low, then 1 from the first cycle after release.
- Latency: a request accepted at edge k gives rsp_valid=1 after edge k+1+WAIT_STATES.
- Throughput: one transaction per 2+WAIT_STATES cycles when rsp_ready is held at 1.
- req_ready is 0 in WAIT and RESP. Requests presented then are ignored, not queued.
- Backpressure: RESP holds indefinitely while rsp_ready=0, with outputs unchanged.
- A store is committed exactly once, on the WAIT/accept→RESP edge, independent of rsp_ready.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; the pending response is dropped.
  - A store not yet committed is lost.
  - A store already committed stays in memory.
- A request is accepted in the same cycle that IDLE is entered, not before. There is no bypass from RESP.

## Structure
- Package riscv_mem_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum dmem_state_t with values IDLE, WAIT, RESP.
- Combinational sub-module dmem_lane_align:
  - Inputs: fn3, addr[1:0], wdata, stored word.
  - Outputs: byte-enable[3:0], merged write word, extended load value, misalign flag.
- The FSM, counter and storage array live in dmem_responder.

## Test plan
- Reset release with req_valid=0: req_ready goes 0→1 and rsp_valid stays 0. With WAIT_STATES=1, SW 0xDEADBEEF to 0x10 then LW 0x10 gives rsp_rdata=0xDEADBEEF, and rsp_valid rises 2 cycles after each accept.
- After SW 0x11223344 to 0x20, SB 0x80 to 0x23:
  - LW 0x20 gives 0x80223344.
  - LB 0x23 gives 0xFFFFFF80.
  - LBU 0x23 gives 0x00000080.
  - LH 0x22 gives 0xFFFF8022.
- LH at 0x21, SW at 0x06, fn3=011 and LW at 4*DEPTH_WORDS: each gives rsp_err=1 and rsp_rdata=0. A subsequent LW at the stored word shows it is unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP while driving a new req_valid: rsp_valid and rsp_rdata are stable and req_ready=0. After the handshake, the new request is accepted one cycle later.
- Assert reset during WAIT of an SW 0xCAFEF00D to 0x30 with WAIT_STATES=3: rsp_valid=0 and the FSM is in IDLE. A later LW 0x30 returns the old contents.
- Rerun the read/write scenario with WAIT_STATES=0: latency is 1 cycle.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the handshaked data-memory path: funct3 encodings,
// responder state type and the funct3 legality rule for loads and stores.
package riscv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // Unsigned variants only exist for loads.
   function automatic logic fn3_legal(input logic is_write, input logic [2:0] fn3);
      logic ok;
      case (fn3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !is_write;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RISC-V loads/stores: store byte enables and merged
// write word, load extraction with sign/zero extension, and misalignment.
module dmem_lane_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  fn3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] stored_word,
   output logic [3:0]  byte_en,
   output logic [31:0] merged_word,
   output logic [31:0] load_value,
   output logic        misalign
);

   logic [31:0] lane_data;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      byte_en   = 4'b0000;
      lane_data = 32'h0000_0000;
      misalign  = 1'b0;
      case (fn3)
         F3_B, F3_BU: begin
            byte_en   = 4'b0001 << addr_lo;
            lane_data = {4{wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata[15:0]}};
            misalign  = addr_lo[0];
         end
         F3_W: begin
            byte_en   = 4'b1111;
            lane_data = wdata;
            misalign  = (addr_lo != 2'b00);
         end
         default: begin
            byte_en   = 4'b0000;
            lane_data = 32'h0000_0000;
            misalign  = 1'b0;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_merge
         assign merged_word[gi*8 +: 8] = byte_en[gi] ? lane_data[gi*8 +: 8]
                                                     : stored_word[gi*8 +: 8];
      end
   endgenerate

   assign sel_byte = stored_word[{addr_lo, 3'b000} +: 8];
   assign sel_half = addr_lo[1] ? stored_word[31:16] : stored_word[15:0];

   always_comb begin
      load_value = 32'h0000_0000;
      case (fn3)
         F3_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   load_value = {24'h000000, sel_byte};
         F3_H:    load_value = {{16{sel_half[15]}}, sel_half};
         F3_HU:   load_value = {16'h0000, sel_half};
         F3_W:    load_value = stored_word;
         default: load_value = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: one request at a time over valid/ready,
// WAIT_STATES extra cycles, then a held response with load data or error.
module dmem_responder
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_fn3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   dmem_state_t state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        req_ready_reg;
   logic        write_reg;
   logic [2:0]  fn3_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        err_reg;

   logic        accept;
   logic        going_resp;
   logic        do_write;
   logic        cur_write;
   logic [2:0]  cur_fn3;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic        cur_err;
   logic        range_err;
   logic [IDX_W-1:0] idx;

   logic [3:0]  byte_en;
   logic [31:0] merged_word;
   logic [31:0] load_value;
   logic        misalign;
   logic [31:0] stored_word;

   assign accept = (state_reg == IDLE) && req_valid && req_ready_reg;

   // In IDLE the accepting request is live on the inputs (needed when
   // WAIT_STATES=0); afterwards the latched copy drives the datapath.
   assign cur_write = (state_reg == IDLE) ? req_write : write_reg;
   assign cur_fn3   = (state_reg == IDLE) ? req_fn3   : fn3_reg;
   assign cur_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
   assign cur_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

   assign range_err = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign cur_err   = !fn3_legal(cur_write, cur_fn3) || misalign || range_err;
   assign idx       = cur_addr[IDX_W+1:2];
   assign do_write  = going_resp && cur_write && !cur_err;

   dmem_lane_align u_lane_align (
      .fn3         (cur_fn3),
      .addr_lo     (cur_addr[1:0]),
      .wdata       (cur_wdata),
      .stored_word (stored_word),
      .byte_en     (byte_en),
      .merged_word (merged_word),
      .load_value  (load_value),
      .misalign    (misalign)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      going_resp = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_next = RESP;
                  going_resp = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = RESP;
               going_resp = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         req_ready_reg <= 1'b0;
         write_reg     <= 1'b0;
         fn3_reg       <= 3'b000;
         addr_reg      <= 32'h0000_0000;
         wdata_reg     <= 32'h0000_0000;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         req_ready_reg <= (state_next == IDLE);
         if (accept) begin
            write_reg <= req_write;
            fn3_reg   <= req_fn3;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
         end
         if (going_resp) err_reg <= cur_err;
      end
   end

   // One byte-wide RAM per lane; write commit and read capture share the
   // edge into RESP, and the read register stays put for the whole response.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];
         logic [7:0] rd_q;
         always_ff @(posedge clk) begin
            if (do_write && byte_en[gi]) lane_mem[idx] <= merged_word[gi*8 +: 8];
            if (going_resp) rd_q <= lane_mem[idx];
         end
         assign stored_word[gi*8 +: 8] = rd_q;
      end
   endgenerate

   assign req_ready = req_ready_reg;
   assign rsp_valid = (state_reg == RESP);
   assign rsp_err   = rsp_valid && err_reg;
   assign rsp_rdata = (rsp_valid && !err_reg && !write_reg) ? load_value : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 3) on a shared clock
// and reset, exercising lanes, errors, backpressure and mid-transaction reset.
module tb_dmem_responder;
   import riscv_mem_pkg::*;

   logic        clk;
   logic        reset;
   logic [2:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
   logic [2:0]  req_fn3   [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [31:0] rsp_rdata [3];

   int vectors;
   int miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_fn3(req_fn3[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_fn3(req_fn3[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_write(req_write[2]), .req_fn3(req_fn3[2]), .req_addr(req_addr[2]),
      .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
      .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

   // Present a request and return just after the edge that accepts it.
   task automatic issue(input int d, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd);
      bit found;
      found        = 1'b0;
      req_write[d] = w;
      req_fn3[d]   = f;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_valid[d] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready[d]) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: dut %0d req_ready never 1, required 1", d);
      end
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
   endtask

   // Count negedges after the accept edge until rsp_valid, then sample.
   task automatic wait_rsp(input int d, output int n, output logic [31:0] rd, output logic er);
      bit found;
      found = 1'b0;
      n     = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n++;
         if (rsp_valid[d]) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $display("FAIL rsp_timeout: dut %0d rsp_valid never 1, required 1", d);
      end
      rd = rsp_rdata[d];
      er = rsp_err[d];
   endtask

   task automatic release_rsp(input int d);
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[d] = 1'b0;
   endtask

   task automatic txn(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, output int n, output logic [31:0] rd, output logic er);
      issue(d, w, f, a, wd);
      wait_rsp(d, n, rd, er);
      release_rsp(d);
      $display("txn dut=%0d write=%0d fn3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
               d, w, f, a, wd, rd, er, n);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (req_ready !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_ready_low: got %b required 000", req_ready);
      end
      vectors++;
      if (rsp_valid !== 3'b000 || rsp_err !== 3'b000 || rsp_rdata[0] !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_rsp: valid=%b err=%b rdata=%h required 000/000/0", rsp_valid, rsp_err, rsp_rdata[0]);
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 3'b111 || rsp_valid !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_release: ready=%b valid=%b required 111/000", req_ready, rsp_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_read_write(input int d, input int exp_lat);
      int n;
      logic [31:0] rd;
      logic er;
      txn(d, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, n, rd, er);
      vectors++;
      if (n !== exp_lat || rd !== 32'h0 || er !== 1'b0) begin
         miscompares++;
         $display("FAIL rw_sw dut%0d: lat=%0d rdata=%h err=%0d required lat=%0d 0/0", d, n, rd, er, exp_lat);
      end
      txn(d, 1'b0, F3_W, 32'h10, 32'h0, n, rd, er);
      vectors++;
      if (n !== exp_lat || rd !== 32'hDEADBEEF || er !== 1'b0) begin
         miscompares++;
         $display("FAIL rw_lw dut%0d: lat=%0d rdata=%h err=%0d required lat=%0d deadbeef/0", d, n, rd, er, exp_lat);
      end
   endtask

   task automatic test_lanes();
      int n;
      logic [31:0] rd;
      logic er;
      logic [2:0]  fns  [6] = '{F3_W, F3_B, F3_BU, F3_H, F3_HU, F3_H};
      logic [31:0] adrs [6] = '{32'h20, 32'h23, 32'h23, 32'h22, 32'h20, 32'h20};
      logic [31:0] exps [6] = '{32'h80223344, 32'hFFFFFF80, 32'h00000080,
                                32'hFFFF8022, 32'h00003344, 32'h00003344};
      txn(0, 1'b1, F3_W, 32'h20, 32'h11223344, n, rd, er);
      txn(0, 1'b1, F3_B, 32'h23, 32'hAAAAAA80, n, rd, er);
      for (int i = 0; i < 6; i++) begin
         txn(0, 1'b0, fns[i], adrs[i], 32'h0, n, rd, er);
         vectors++;
         if (rd !== exps[i] || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lane_load%0d: rdata=%h err=%0d required %h/0", i, rd, er, exps[i]);
         end
      end
      txn(0, 1'b1, F3_H, 32'h22, 32'h5555C0DE, n, rd, er);
      txn(0, 1'b0, F3_W, 32'h20, 32'h0, n, rd, er);
      vectors++;
      if (rd !== 32'hC0DE3344) begin
         miscompares++;
         $display("FAIL lane_sh: rdata=%h required c0de3344", rd);
      end
   endtask

   task automatic test_errors();
      int n;
      logic [31:0] rd;
      logic er;
      logic        ws [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0]  fns [5] = '{F3_H, F3_W, 3'b011, F3_W, F3_BU};
      logic [31:0] adrs [5] = '{32'h21, 32'h06, 32'h20, 32'h100, 32'h04};
      txn(0, 1'b1, F3_W, 32'h04, 32'h13579BDF, n, rd, er);
      for (int i = 0; i < 5; i++) begin
         txn(0, ws[i], fns[i], adrs[i], 32'hFFFFFFFF, n, rd, er);
         vectors++;
         if (er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL err_case%0d: err=%0d rdata=%h required 1/0", i, er, rd);
         end
      end
      txn(0, 1'b0, F3_W, 32'h04, 32'h0, n, rd, er);
      vectors++;
      if (rd !== 32'h13579BDF || er !== 1'b0) begin
         miscompares++;
         $display("FAIL err_unchanged: rdata=%h err=%0d required 13579bdf/0", rd, er);
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [31:0] rd;
      logic er;
      issue(0, 1'b0, F3_W, 32'h04, 32'h0);
      wait_rsp(0, n, rd, er);
      req_write[0] = 1'b0;
      req_fn3[0]   = F3_W;
      req_addr[0]  = 32'h10;
      req_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h13579BDF || req_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: valid=%0d rdata=%h ready=%0d required 1/13579bdf/0",
                     i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
         end
      end
      release_rsp(0);
      $display("txn dut=0 write=0 fn3=2 addr=00000004 held 5 cycles -> rdata=%h", rd);
      @(negedge clk);
      vectors++;
      if (req_ready[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_reaccept: req_ready=%0d required 1", req_ready[0]);
      end
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      wait_rsp(0, n, rd, er);
      release_rsp(0);
      $display("txn dut=0 write=0 fn3=2 addr=00000010 -> rdata=%h err=%0d lat=%0d", rd, er, n);
      vectors++;
      if (n !== 2 || rd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL bp_next: lat=%0d rdata=%h required 2/deadbeef", n, rd);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [31:0] rd;
      logic er;
      bit seen;
      txn(2, 1'b1, F3_W, 32'h30, 32'h0BADCAFE, n, rd, er);
      vectors++;
      if (n !== 4) begin
         miscompares++;
         $display("FAIL mid_ws3_latency: got %0d required 4", n);
      end
      issue(2, 1'b1, F3_W, 32'h30, 32'hCAFEF00D);
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_assert: valid=%0d ready=%0d required 0/0", rsp_valid[2], req_ready[2]);
      end
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid[2]) seen = 1'b1;
      end
      vectors++;
      if (seen || req_ready[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_idle: rsp_valid_seen=%0d ready=%0d required 0/1", seen, req_ready[2]);
      end
      @(posedge clk);
      #1;
      txn(2, 1'b0, F3_W, 32'h30, 32'h0, n, rd, er);
      vectors++;
      if (rd !== 32'h0BADCAFE || er !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_lost_store: rdata=%h required 0badcafe", rd);
      end
      txn(0, 1'b0, F3_W, 32'h10, 32'h0, n, rd, er);
      vectors++;
      if (rd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL mid_storage_kept: rdata=%h required deadbeef", rd);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      req_valid   = 3'b000;
      req_write   = 3'b000;
      rsp_ready   = 3'b000;
      for (int i = 0; i < 3; i++) begin
         req_fn3[i]   = 3'b000;
         req_addr[i]  = 32'h0;
         req_wdata[i] = 32'h0;
      end
      test_reset();
      test_read_write(0, 2);
      test_read_write(1, 1);
      test_lanes();
      test_errors();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
